// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_queue
// Function : Instruction prefetch queue in front of the IF/ID register.
//            Owns the fetch PC, fetches from a variable-latency memory with
//            a single outstanding req/ack transaction, buffers words with
//            their PC+4 in a small FIFO and flushes on ID-stage redirects.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_ins,
    output logic [31:0] out_pc,
    input  logic        out_ready
);

    localparam int           AW   = $clog2(DEPTH);
    localparam logic [AW:0]  FULL = DEPTH[AW:0];

    // DRAIN: waiting out a request that became stale because of a redirect
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]    state, state_next;
    logic [31:0]   fetch_pc, fetch_pc_next, addr_next, addr_inc;
    logic [31:0]   ins_mem [DEPTH];
    logic [31:0]   pc_mem  [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count, count_after_pop, count_next;
    logic          pop, push, flush;

    assign out_valid       = (count != '0);
    assign out_ins         = out_valid ? ins_mem[rd_ptr] : 32'h0;
    assign out_pc          = out_valid ? pc_mem[rd_ptr]  : 32'h0;
    assign pop             = out_valid & out_ready;
    // a word returned alongside a redirect belongs to the old path: never stored
    assign push            = (state == REQ) & imem_ack & ~redirect;
    assign addr_inc        = imem_addr + 32'd4;
    assign count_after_pop = count - {{AW{1'b0}}, pop};
    assign count_next      = count_after_pop + {{AW{1'b0}}, push};

    // Next-state, next fetch PC and next request address
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        addr_next     = imem_addr;
        flush         = 1'b0;
        case (state)
            IDLE: begin
                if (redirect) begin
                    flush         = 1'b1;
                    fetch_pc_next = redirect_pc;
                    addr_next     = redirect_pc;
                    state_next    = REQ;
                end else if (count_after_pop < FULL) begin
                    addr_next  = fetch_pc;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    flush         = 1'b1;
                    fetch_pc_next = redirect_pc;
                    if (imem_ack) begin
                        addr_next = redirect_pc;
                    end else begin
                        // request cannot be withdrawn; hold address until ack
                        state_next = DRAIN;
                    end
                end else if (imem_ack) begin
                    fetch_pc_next = addr_inc;
                    if (count_next < FULL) begin
                        addr_next = addr_inc;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (redirect) begin
                    flush         = 1'b1;
                    fetch_pc_next = redirect_pc;
                end
                if (imem_ack) begin
                    addr_next  = redirect ? redirect_pc : fetch_pc;
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control state, fetch PC and registered memory request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            state     <= state_next;
            fetch_pc  <= fetch_pc_next;
            imem_req  <= (state_next != IDLE);
            imem_addr <= addr_next;
        end
    end

    // FIFO pointers and occupancy; flush overrides push and pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    // FIFO storage: instruction word and its fall-through PC
    always_ff @(posedge clk) begin
        if (push) begin
            ins_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]  <= addr_inc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_queue
// Function : Self-checking bench for ifetch_queue. A memory model answers
//            requests with a random latency; the expected instruction stream
//            is the program order starting at the latest fetch target.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_ins;
    logic [31:0] out_pc;
    logic        out_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int lat_min  = 0;
    int lat_max  = 0;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] sb_next;

    ifetch_queue #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .out_valid  (out_valid),
        .out_ins    (out_ins),
        .out_pc     (out_pc),
        .out_ready  (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents: a distinct word for every address
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Extend the expected program-order stream
    task automatic sb_topup();
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back({word_at(sb_next), sb_next + 32'd4});
            sb_next = sb_next + 32'd4;
        end
    endtask

    // A new fetch target invalidates everything expected so far
    task automatic sb_restart(input logic [31:0] target);
        exp_q.delete();
        sb_next = target;
        sb_topup();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        redirect  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        sb_restart(RESET_PC);
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        sb_restart(target);
    endtask

    // Memory model: one request at a time, random wait states, then ack
    initial begin
        int  wait_left;
        logic busy;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        busy       = 1'b0;
        wait_left  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (imem_req) begin
                if (!busy) begin
                    busy      = 1'b1;
                    wait_left = $urandom_range(lat_max, lat_min);
                end
                if (wait_left == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = word_at(imem_addr);
                    busy       = 1'b0;
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = $urandom;
                    wait_left--;
                end
            end else begin
                imem_ack = 1'b0;
                busy     = 1'b0;
            end
        end
    end

    // Monitor: address stability while waiting, and in-order delivery
    initial begin
        logic        prev_hold;
        logic [31:0] prev_addr;
        exp_t        e;
        prev_hold = 1'b0;
        prev_addr = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    chk("req_held", 32'(imem_req), 32'd1);
                    chk("addr_held", imem_addr, prev_addr);
                end
                prev_hold = imem_req && !imem_ack;
                prev_addr = imem_addr;
                if (out_valid && out_ready && !redirect) begin
                    if (exp_q.size() == 0) sb_topup();
                    e = exp_q.pop_front();
                    chk("pop_ins", out_ins, e.ins);
                    chk("pop_pc", out_pc, e.pc);
                    if (exp_q.size() < 8) sb_topup();
                end
            end
        end
    end

    initial begin
        int   bub;
        logic found;
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        out_ready   = 1'b0;
        sb_next     = RESET_PC;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ins", out_ins, 32'h0);
        chk("rst_pc", out_pc, 32'h0);

        // Zero-wait streaming: first valid 2 cycles after release, no bubbles
        lat_min = 0; lat_max = 0;
        @(posedge clk);
        #1;
        rst       = 1'b1;
        out_ready = 1'b1;
        sb_restart(RESET_PC);
        @(posedge clk);
        @(negedge clk);
        chk("t1_valid_cyc1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid_cyc2", 32'(out_valid), 32'd1);
        chk("t1_first_pc", out_pc, 32'd4);
        bub = 0;
        repeat (20) begin
            @(negedge clk);
            if (!out_valid) bub++;
        end
        chk("t1_bubbles", bub, 0);

        // Back-pressure: fill to depth, stop, then one pop restarts fetch
        do_reset();
        repeat (10) @(negedge clk);
        chk("t2_req_stopped", 32'(imem_req), 32'd0);
        chk("t2_last_addr", imem_addr, 32'd12);
        chk("t2_head_pc", out_pc, 32'd4);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("t2_refill_req", 32'(imem_req), 32'd1);
        chk("t2_refill_addr", imem_addr, 32'd16);
        chk("t2_new_head_pc", out_pc, 32'd8);

        // Redirect while a slow request is outstanding
        do_reset();
        lat_min = 3; lat_max = 3;
        out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h8) found = 1'b1;
        end
        chk("t3_saw_req8", 32'(found), 32'd1);
        @(posedge clk);
        #1;
        do_redirect(32'h100);
        @(posedge clk);
        #1;
        redirect = 1'b0;
        @(negedge clk);
        chk("t3_drain_req", 32'(imem_req), 32'd1);
        chk("t3_drain_addr", imem_addr, 32'h8);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h100) found = 1'b1;
        end
        chk("t3_saw_req100", 32'(found), 32'd1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (out_valid) found = 1'b1;
            else @(negedge clk);
        end
        chk("t3_got_valid", 32'(found), 32'd1);
        chk("t3_first_pc", out_pc, 32'h104);
        repeat (20) @(negedge clk);

        // Redirect coinciding with ack and pop while two entries are queued
        do_reset();
        lat_min = 0; lat_max = 0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        do_redirect(32'h40);
        @(negedge clk);
        chk("t4_head_pc", out_pc, 32'd4);
        @(posedge clk);
        #1;
        redirect = 1'b0;
        @(negedge clk);
        chk("t4_valid_dropped", 32'(out_valid), 32'd0);
        chk("t4_addr", imem_addr, 32'h40);
        repeat (10) @(negedge clk);

        // Asynchronous reset in the middle of an acked request
        do_reset();
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("t6_req", 32'(imem_req), 32'd0);
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_addr", imem_addr, RESET_PC);
        chk("t6_ins", out_ins, 32'h0);
        chk("t6_pc", out_pc, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb_restart(RESET_PC);
        @(posedge clk);
        @(negedge clk);
        chk("t6_restart_req", 32'(imem_req), 32'd1);
        chk("t6_restart_addr", imem_addr, RESET_PC);

        // Randomized traffic: latency, back-pressure and redirects
        do_reset();
        lat_min = 0; lat_max = 3;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                if ($urandom_range(0, 3) == 0)
                    do_redirect(32'hFFFF_FFF0);
                else
                    do_redirect($urandom & 32'hFFFF_FFFC);
            end else begin
                redirect = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        redirect = 1'b0;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
